controlador_acesso_memoria: RTL and testbench
=============================================

Name: controlador_acesso_memoria

Overview:
- Initiator side of the halfword data-memory interface.
- Accepts one load/store request at a time from the execute stage over a valid/ready handshake.
- Sequences the halfword-only memory port to implement lb/lbu/lh/lhu/lw and sb/sh/sw, using read-modify-write for byte stores and two beats for words.
- Returns a one-cycle completion pulse with extended load data or an alignment error.

Parameters:
- VERIFICAR_ALINHAMENTO, 1. 1: a misaligned half/word request raises an error and makes no memory access. 0: low address bits are forced to alignment (A&~1 for half, A&~3 for word) and the access proceeds.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- req_valido  input  1  request present
- req_pronto  output  1  controller can accept a request; high only in OCIOSO
- req_escrita  input  1  1=store, 0=load
- req_tamanho  input  2  00 byte, 01 half, 10 word, 11 illegal
- req_sem_sinal  input  1  zero-extend loads (lbu/lhu); ignored for word and stores
- req_endereco  input  32  byte address A
- req_dados  input  32  store data
- resp_valido  output  1  one-cycle completion pulse
- resp_dados  output  32  load result; 0 for stores and errors
- erro_alinhamento  output  1  valid with resp_valido; misaligned access or illegal size
- mem_endereco  output  32  halfword address to memory
- mem_dados_escrita  output  32  [15:0] halfword to write; [31:16]=0
- mem_ler  output  1  memory read enable
- mem_escrever  output  1  memory write enable (memory writes at posedge)
- mem_dados_leitura  input  32  combinational memory read; only [15:0] used

Behaviour:
- Handshake: a request is accepted on a posedge with req_valido&&req_pronto. All req_* are captured at acceptance. req_* changes while busy have no effect.
- States: OCIOSO, FASE1, FASE2, FIM.
  - OCIOSO→FASE1 on accept.
  - OCIOSO→FIM directly on error: illegal size, half with A[0]=1, or word with A[1:0]!=0 when VERIFICAR_ALINHAMENTO=1.
  - FASE1→FASE2 for word and sb; FASE1→FIM otherwise.
  - FASE2→FIM.
  - FIM→OCIOSO.
- mem_ler, mem_escrever and mem_endereco are decoded from the registered state and captured request. In OCIOSO and FIM all mem_* are 0.
- Every memory access is halfword-aligned: mem_endereco[0]=0 always. Let Ah=A&~1.
- lb/lbu: FASE1 read Ah. byte=A[0]?d[15:8]:d[7:0]. Sign- or zero-extend to 32 bits.
- lh/lhu: FASE1 read Ah. d[15:0] is sign- or zero-extended to 32 bits.
- lw: FASE1 read A, capture low half; FASE2 read A+2. Result={hi,lo}.
- sh: FASE1 write Ah with req_dados[15:0].
- sb: FASE1 read Ah, capture old; FASE2 write Ah with A[0] ? {new,old[7:0]} : {old[15:8],new}.
- sw: FASE1 write A with req_dados[15:0]; FASE2 write A+2 with req_dados[31:16].
- Read data is captured at the posedge ending the read phase.
- FIM: resp_valido=1 for exactly one cycle.
  - resp_dados and erro_alinhamento are registered and hold until the next FIM.
  - Error responses: resp_dados=0, erro_alinhamento=1.
- Latency, counted in cycles after the accepting edge until resp_valido is high:
  - 1: error
  - 2: lb/lbu/lh/lhu/sh
  - 3: lw/sw/sb
- Maximum throughput is one request per 2–4 cycles. There is no acceptance in FIM.
- Reset: asynchronous. State→OCIOSO; resp_dados=0; resp_valido=0; erro_alinhamento=0; captured registers=0.
  - mem_ler/mem_escrever drop immediately on reset assertion. An aborted request produces no response.
  - An sw aborted between FASE1 and FASE2 may leave only the low half written. No recovery is performed.
- Address arithmetic A+2 is 32-bit with no wrap handling. Memory decodes address bits [9:0].

Test Plan:
- Bench instantiates the team's 1 KB halfword data memory, reset to zero.
- sw 0x12345678 @0x100: mem writes (0x100,0x5678) then (0x102,0x1234); resp_valido 3 cycles after accept, resp_dados=0, erro=0. Then lw @0x100 → resp_dados=0x12345678.
- sb 0xAB @0x101 after the above: FASE1 read 0x100, FASE2 write 0x100 data 0xAB78. lw @0x100 → 0x1234AB78; lbu @0x101 → 0x000000AB; lb @0x101 → 0xFFFFFFAB; lb @0x100 → 0x00000078.
- sh 0x8001 @0x200 (latency 2). lh @0x200 → 0xFFFF8001; lhu @0x200 → 0x00008001.
- lh @0x203, VERIFICAR_ALINHAMENTO=1 → resp_valido 1 cycle after accept, erro=1, resp_dados=0, mem_ler/mem_escrever never high. Repeat with req_tamanho=11 → same result.
- Hold req_valido high with changing req_* during an lw: req_pronto stays low until OCIOSO, the first result is unaffected, and the second request is accepted on the cycle after FIM.
- Assert reset during FASE2 of sw 0xCAFEBABE @0x300: all outputs 0 immediately, no resp_valido, req_pronto=1 after release. A following lh @0x300 completes normally.

Source files
------------

// File: rtl/controlador_acesso_memoria.sv
// Load/store initiator for the halfword-only data memory port.
// Bytes use read-modify-write on stores; words take two halfword beats.
module controlador_acesso_memoria #(
  parameter bit VERIFICAR_ALINHAMENTO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valido,
  output logic        req_pronto,
  input  logic        req_escrita,
  input  logic [1:0]  req_tamanho,
  input  logic        req_sem_sinal,
  input  logic [31:0] req_endereco,
  input  logic [31:0] req_dados,
  output logic        resp_valido,
  output logic [31:0] resp_dados,
  output logic        erro_alinhamento,
  output logic [31:0] mem_endereco,
  output logic [31:0] mem_dados_escrita,
  output logic        mem_ler,
  output logic        mem_escrever,
  input  logic [31:0] mem_dados_leitura
);

  typedef enum logic [1:0] {OCIOSO, FASE1, FASE2, FIM} estado_t;

  estado_t     r_estado;
  logic        r_escrita;
  logic        r_sem_sinal;
  logic [1:0]  r_tamanho;
  logic [31:0] r_endereco;
  logic [31:0] r_dados;
  logic [15:0] r_meia;
  logic [31:0] r_resp_dados;
  logic        r_erro;

  logic        w_desalinhado;
  logic        w_erro_req;
  logic [31:0] w_end_alinhado;
  logic        w_eh_palavra;
  logic        w_eh_sb;
  logic [31:0] w_end_meia;
  logic [7:0]  w_byte;
  logic [31:0] w_carga;
  logic [15:0] w_byte_mesclado;
  logic [15:0] w_meia_escrita;
  logic        w_unused;

  assign w_unused = ^mem_dados_leitura[31:16];

  assign w_desalinhado = (req_tamanho == 2'b01 && req_endereco[0]) ||
                         (req_tamanho == 2'b10 && req_endereco[1:0] != 2'b00);
  assign w_erro_req    = (req_tamanho == 2'b11) || (VERIFICAR_ALINHAMENTO && w_desalinhado);

  // With checking disabled, misaligned half/word addresses are silently rounded down.
  always_comb begin
    w_end_alinhado = req_endereco;
    case (req_tamanho)
      2'b01:   w_end_alinhado = {req_endereco[31:1], 1'b0};
      2'b10:   w_end_alinhado = {req_endereco[31:2], 2'b00};
      default: w_end_alinhado = req_endereco;
    endcase
  end

  assign w_eh_palavra = (r_tamanho == 2'b10);
  assign w_eh_sb      = r_escrita && (r_tamanho == 2'b00);
  assign w_end_meia   = {r_endereco[31:1], 1'b0};
  assign w_byte       = r_endereco[0] ? mem_dados_leitura[15:8] : mem_dados_leitura[7:0];

  always_comb begin
    w_carga = 32'h0;
    case (r_tamanho)
      2'b00:   w_carga = r_sem_sinal ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_carga = r_sem_sinal ? {16'h0, mem_dados_leitura[15:0]}
                                     : {{16{mem_dados_leitura[15]}}, mem_dados_leitura[15:0]};
      default: w_carga = 32'h0;
    endcase
  end

  assign w_byte_mesclado = r_endereco[0] ? {r_dados[7:0], r_meia[7:0]}
                                         : {r_meia[15:8], r_dados[7:0]};

  always_comb begin
    mem_ler        = 1'b0;
    mem_escrever   = 1'b0;
    mem_endereco   = 32'h0;
    w_meia_escrita = 16'h0;
    case (r_estado)
      FASE1: begin
        mem_endereco = w_end_meia;
        if (!r_escrita || w_eh_sb) begin
          mem_ler = 1'b1;
        end else begin
          mem_escrever   = 1'b1;
          w_meia_escrita = r_dados[15:0];
        end
      end
      FASE2: begin
        if (w_eh_palavra) begin
          mem_endereco = w_end_meia + 32'd2;
          if (r_escrita) begin
            mem_escrever   = 1'b1;
            w_meia_escrita = r_dados[31:16];
          end else begin
            mem_ler = 1'b1;
          end
        end else begin
          mem_endereco   = w_end_meia;
          mem_escrever   = 1'b1;
          w_meia_escrita = w_byte_mesclado;
        end
      end
      default: begin
        mem_ler = 1'b0;
      end
    endcase
  end

  assign mem_dados_escrita = {16'h0, w_meia_escrita};
  assign req_pronto        = (r_estado == OCIOSO);
  assign resp_valido       = (r_estado == FIM);
  assign resp_dados        = r_resp_dados;
  assign erro_alinhamento  = r_erro;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_estado     <= OCIOSO;
      r_escrita    <= 1'b0;
      r_sem_sinal  <= 1'b0;
      r_tamanho    <= 2'b00;
      r_endereco   <= 32'h0;
      r_dados      <= 32'h0;
      r_meia       <= 16'h0;
      r_resp_dados <= 32'h0;
      r_erro       <= 1'b0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (req_valido) begin
            r_escrita   <= req_escrita;
            r_sem_sinal <= req_sem_sinal;
            r_tamanho   <= req_tamanho;
            r_endereco  <= w_end_alinhado;
            r_dados     <= req_dados;
            if (w_erro_req) begin
              r_estado     <= FIM;
              r_resp_dados <= 32'h0;
              r_erro       <= 1'b1;
            end else begin
              r_estado <= FASE1;
            end
          end
        end
        FASE1: begin
          // Low half of lw, or the old halfword of sb, is kept for the second beat.
          r_meia <= mem_dados_leitura[15:0];
          if (w_eh_palavra || w_eh_sb) begin
            r_estado <= FASE2;
          end else begin
            r_estado     <= FIM;
            r_resp_dados <= r_escrita ? 32'h0 : w_carga;
            r_erro       <= 1'b0;
          end
        end
        FASE2: begin
          r_estado     <= FIM;
          r_resp_dados <= (w_eh_palavra && !r_escrita) ? {mem_dados_leitura[15:0], r_meia} : 32'h0;
          r_erro       <= 1'b0;
        end
        FIM: begin
          r_estado <= OCIOSO;
        end
        default: begin
          r_estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_acesso_memoria.sv
// Bench for controlador_acesso_memoria: directed scenarios plus random loads/stores
// checked against a byte-array memory model.
module tb_controlador_acesso_memoria;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valido;
  logic        req_pronto;
  logic        req_escrita;
  logic [1:0]  req_tamanho;
  logic        req_sem_sinal;
  logic [31:0] req_endereco;
  logic [31:0] req_dados;
  logic        resp_valido;
  logic [31:0] resp_dados;
  logic        erro_alinhamento;
  logic [31:0] mem_endereco;
  logic [31:0] mem_dados_escrita;
  logic        mem_ler;
  logic        mem_escrever;
  logic [31:0] mem_dados_leitura;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  controlador_acesso_memoria #(.VERIFICAR_ALINHAMENTO(1'b1)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valido        (req_valido),
    .req_pronto        (req_pronto),
    .req_escrita       (req_escrita),
    .req_tamanho       (req_tamanho),
    .req_sem_sinal     (req_sem_sinal),
    .req_endereco      (req_endereco),
    .req_dados         (req_dados),
    .resp_valido       (resp_valido),
    .resp_dados        (resp_dados),
    .erro_alinhamento  (erro_alinhamento),
    .mem_endereco      (mem_endereco),
    .mem_dados_escrita (mem_dados_escrita),
    .mem_ler           (mem_ler),
    .mem_escrever      (mem_escrever),
    .mem_dados_leitura (mem_dados_leitura)
  );

  // 1 KB halfword memory: combinational read, write at posedge.
  logic [15:0] mem_ram [0:511] = '{default: 16'h0};
  assign mem_dados_leitura = {16'h0, mem_ram[mem_endereco[9:1]]};
  always @(posedge clk) begin
    if (mem_escrever) mem_ram[mem_endereco[9:1]] <= mem_dados_escrita[15:0];
  end

  // Access log: {write, address, write data}
  logic [48:0] log_q[$];
  always @(posedge clk) begin
    if (mem_ler || mem_escrever) log_q.push_back({mem_escrever, mem_endereco, mem_dados_escrita[15:0]});
  end

  // Reference model: little-endian byte array
  logic [7:0] ref_mem [0:1023];

  function automatic bit model_err(input logic [1:0] tam, input logic [31:0] a);
    return (tam == 2'd3) || (tam == 2'd1 && a[0]) || (tam == 2'd2 && a[1:0] != 2'b00);
  endfunction

  function automatic int model_lat(input logic w, input logic [1:0] tam, input logic [31:0] a);
    if (model_err(tam, a)) return 1;
    if (tam == 2'd2 || (w && tam == 2'd0)) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] tam, input logic s, input logic [31:0] a);
    logic [9:0] i;
    logic [7:0] b0, b1, b2, b3;
    i  = a[9:0];
    b0 = ref_mem[i];
    b1 = ref_mem[i + 10'd1];
    b2 = ref_mem[i + 10'd2];
    b3 = ref_mem[i + 10'd3];
    case (tam)
      2'd0:    return s ? {24'h0, b0} : {{24{b0[7]}}, b0};
      2'd1:    return s ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      default: return {b3, b2, b1, b0};
    endcase
  endfunction

  task automatic model_store(input logic [1:0] tam, input logic [31:0] a, input logic [31:0] d);
    logic [9:0] i;
    i = a[9:0];
    ref_mem[i] = d[7:0];
    if (tam != 2'd0) ref_mem[i + 10'd1] = d[15:8];
    if (tam == 2'd2) begin
      ref_mem[i + 10'd2] = d[23:16];
      ref_mem[i + 10'd3] = d[31:24];
    end
  endtask

  task automatic randomize_req();
    req_escrita   = 1'($urandom);
    req_tamanho   = 2'($urandom);
    req_sem_sinal = 1'($urandom);
    req_endereco  = $urandom;
    req_dados     = $urandom;
  endtask

  // Issue one request, scramble the inputs after acceptance, return latency and response.
  task automatic do_req(input logic w, input logic [1:0] tam, input logic s,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic er);
    int espera;
    @(negedge clk);
    req_valido = 1'b1; req_escrita = w; req_tamanho = tam;
    req_sem_sinal = s; req_endereco = a; req_dados = d;
    espera = 0;
    while (!req_pronto && espera < 10) begin
      @(negedge clk);
      espera++;
    end
    @(posedge clk);
    #1;
    req_valido = 1'b0;
    randomize_req();
    lat = 0; rd = 'x; er = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (resp_valido) begin
        lat = k; rd = resp_dados; er = erro_alinhamento;
        break;
      end
    end
    if (lat == 0) begin
      n_vec++; n_err++;
      $display("FAIL resp_timeout: no resp_valido for addr %h tam %0d, required within 8 cycles", a, tam);
    end
    if (w && !model_err(tam, a)) model_store(tam, a, d);
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valido = 1'b0;
    req_escrita = 0; req_tamanho = 0; req_sem_sinal = 0; req_endereco = 0; req_dados = 0;
    #12;
    n_vec++; if (resp_valido !== 1'b0) begin n_err++; $display("FAIL rst_resp_valido: got %b want 0", resp_valido); end
    n_vec++; if (resp_dados !== 32'h0) begin n_err++; $display("FAIL rst_resp_dados: got %h want 0", resp_dados); end
    n_vec++; if (erro_alinhamento !== 1'b0) begin n_err++; $display("FAIL rst_erro: got %b want 0", erro_alinhamento); end
    n_vec++; if ({mem_ler, mem_escrever} !== 2'b00) begin n_err++; $display("FAIL rst_mem_en: got %b want 00", {mem_ler, mem_escrever}); end
    n_vec++; if (mem_endereco !== 32'h0) begin n_err++; $display("FAIL rst_mem_end: got %h want 0", mem_endereco); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_vec++; if (req_pronto !== 1'b1) begin n_err++; $display("FAIL rst_pronto: got %b want 1", req_pronto); end
  endtask

  task automatic test_sw_lw();
    int lat; logic [31:0] rd; logic er;
    log_q.delete();
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678, lat, rd, er);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL sw_lat: got %0d want 3", lat); end
    n_vec++; if (rd !== 32'h0 || er !== 1'b0) begin n_err++; $display("FAIL sw_resp: got %h/%b want 0/0", rd, er); end
    n_vec++; if (log_q.size() != 2) begin n_err++; $display("FAIL sw_nacc: got %0d want 2", log_q.size()); end
    n_vec++; if (log_q[0] !== {1'b1, 32'h100, 16'h5678}) begin n_err++; $display("FAIL sw_beat0: got %h want %h", log_q[0], {1'b1, 32'h100, 16'h5678}); end
    n_vec++; if (log_q[1] !== {1'b1, 32'h102, 16'h1234}) begin n_err++; $display("FAIL sw_beat1: got %h want %h", log_q[1], {1'b1, 32'h102, 16'h1234}); end
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h12345678 || lat !== 3) begin n_err++; $display("FAIL lw_100: got %h lat %0d want 12345678 lat 3", rd, lat); end
  endtask

  task automatic test_sb();
    int lat; logic [31:0] rd; logic er;
    log_q.delete();
    do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h000000AB, lat, rd, er);
    n_vec++; if (lat !== 3) begin n_err++; $display("FAIL sb_lat: got %0d want 3", lat); end
    n_vec++; if (log_q[0] !== {1'b0, 32'h100, 16'h0}) begin n_err++; $display("FAIL sb_read: got %h want %h", log_q[0], {1'b0, 32'h100, 16'h0}); end
    n_vec++; if (log_q[1] !== {1'b1, 32'h100, 16'hAB78} || log_q.size() != 2) begin n_err++; $display("FAIL sb_write: got %h (n=%0d) want %h", log_q[1], log_q.size(), {1'b1, 32'h100, 16'hAB78}); end
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h1234AB78) begin n_err++; $display("FAIL sb_lw: got %h want 1234ab78", rd); end
    do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h000000AB || lat !== 2) begin n_err++; $display("FAIL lbu_101: got %h lat %0d want 000000ab lat 2", rd, lat); end
    do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'hFFFFFFAB) begin n_err++; $display("FAIL lb_101: got %h want ffffffab", rd); end
    do_req(1'b0, 2'd0, 1'b0, 32'h100, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h00000078) begin n_err++; $display("FAIL lb_100: got %h want 00000078", rd); end
  endtask

  task automatic test_sh();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b1, 2'd1, 1'b0, 32'h200, 32'h00008001, lat, rd, er);
    n_vec++; if (lat !== 2 || rd !== 32'h0) begin n_err++; $display("FAIL sh_200: got lat %0d data %h want lat 2 data 0", lat, rd); end
    do_req(1'b0, 2'd1, 1'b0, 32'h200, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'hFFFF8001) begin n_err++; $display("FAIL lh_200: got %h want ffff8001", rd); end
    do_req(1'b0, 2'd1, 1'b1, 32'h200, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'h00008001) begin n_err++; $display("FAIL lhu_200: got %h want 00008001", rd); end
  endtask

  task automatic test_erro();
    int lat; logic [31:0] rd; logic er;
    log_q.delete();
    do_req(1'b0, 2'd1, 1'b0, 32'h203, 32'h0, lat, rd, er);
    n_vec++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL err_lh_203: got lat %0d erro %b data %h want 1/1/0", lat, er, rd); end
    do_req(1'b0, 2'd3, 1'b0, 32'h200, 32'h0, lat, rd, er);
    n_vec++; if (lat !== 1 || er !== 1'b1 || rd !== 32'h0) begin n_err++; $display("FAIL err_size11: got lat %0d erro %b data %h want 1/1/0", lat, er, rd); end
    do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'hFFFFFFFF, lat, rd, er);
    n_vec++; if (lat !== 1 || er !== 1'b1) begin n_err++; $display("FAIL err_sw_102: got lat %0d erro %b want 1/1", lat, er); end
    n_vec++; if (log_q.size() != 0) begin n_err++; $display("FAIL err_noaccess: got %0d accesses want 0", log_q.size()); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd;
    @(negedge clk);
    req_valido = 1'b1; req_escrita = 1'b0; req_tamanho = 2'd2;
    req_sem_sinal = 1'b0; req_endereco = 32'h100; req_dados = 32'h0;
    @(posedge clk);
    lat = 0; rd = 'x;
    for (int k = 1; k <= 6; k++) begin
      #1 randomize_req();
      @(negedge clk);
      if (resp_valido) begin lat = k; rd = resp_dados; break; end
      n_vec++; if (req_pronto !== 1'b0) begin n_err++; $display("FAIL busy_pronto: got %b want 0 at cycle %0d", req_pronto, k); end
      @(posedge clk);
    end
    n_vec++; if (lat !== 3 || rd !== 32'h1234AB78) begin n_err++; $display("FAIL busy_lw: got lat %0d data %h want 3 1234ab78", lat, rd); end
    n_vec++; if (req_pronto !== 1'b0) begin n_err++; $display("FAIL fim_pronto: got %b want 0", req_pronto); end
    req_escrita = 1'b0; req_tamanho = 2'd1; req_sem_sinal = 1'b1; req_endereco = 32'h200;
    @(negedge clk);
    n_vec++; if (req_pronto !== 1'b1) begin n_err++; $display("FAIL after_fim_pronto: got %b want 1", req_pronto); end
    @(posedge clk);
    #1 req_valido = 1'b0;
    @(negedge clk);
    n_vec++; if (resp_valido !== 1'b0) begin n_err++; $display("FAIL b2b_early: got resp_valido %b want 0", resp_valido); end
    @(negedge clk);
    n_vec++; if (resp_valido !== 1'b1 || resp_dados !== 32'h00008001) begin n_err++; $display("FAIL b2b_lhu: got %b/%h want 1/00008001", resp_valido, resp_dados); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [31:0] rd; logic er; bit visto;
    log_q.delete();
    @(negedge clk);
    req_valido = 1'b1; req_escrita = 1'b1; req_tamanho = 2'd2;
    req_sem_sinal = 1'b0; req_endereco = 32'h300; req_dados = 32'hCAFEBABE;
    while (!req_pronto) @(negedge clk);
    @(posedge clk);
    #1 req_valido = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (mem_escrever !== 1'b1 || mem_endereco !== 32'h302) begin n_err++; $display("FAIL abort_fase2: got we %b addr %h want 1 302", mem_escrever, mem_endereco); end
    #1 reset = 1'b1;
    #1;
    n_vec++; if ({mem_ler, mem_escrever, resp_valido, erro_alinhamento} !== 4'b0) begin n_err++; $display("FAIL abort_ctl: got %b want 0000", {mem_ler, mem_escrever, resp_valido, erro_alinhamento}); end
    n_vec++; if (resp_dados !== 32'h0 || mem_endereco !== 32'h0) begin n_err++; $display("FAIL abort_data: got %h/%h want 0/0", resp_dados, mem_endereco); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    visto = 1'b0;
    @(negedge clk);
    n_vec++; if (req_pronto !== 1'b1) begin n_err++; $display("FAIL abort_pronto: got %b want 1", req_pronto); end
    repeat (3) begin
      if (resp_valido) visto = 1'b1;
      @(negedge clk);
    end
    n_vec++; if (visto !== 1'b0) begin n_err++; $display("FAIL abort_resp: got resp_valido %b want 0", visto); end
    n_vec++; if (log_q.size() != 1 || log_q[0] !== {1'b1, 32'h300, 16'hBABE}) begin n_err++; $display("FAIL abort_log: got n=%0d %h want 1 %h", log_q.size(), log_q[0], {1'b1, 32'h300, 16'hBABE}); end
    model_store(2'd1, 32'h300, 32'h0000BABE);
    do_req(1'b0, 2'd1, 1'b0, 32'h300, 32'h0, lat, rd, er);
    n_vec++; if (rd !== 32'hFFFFBABE || lat !== 2 || er !== 1'b0) begin n_err++; $display("FAIL abort_lh: got %h lat %0d erro %b want ffffbabe 2 0", rd, lat, er); end
  endtask

  task automatic test_random();
    int lat, exp_lat; logic [31:0] rd, exp_rd; logic er;
    logic w, s; logic [1:0] tam; logic [31:0] a, d; bit exp_er;
    for (int n = 0; n < 80; n++) begin
      w   = 1'($urandom);
      s   = 1'($urandom);
      tam = 2'($urandom);
      a   = 32'($urandom_range(0, 1019));
      d   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (tam == 2'd1) a[0] = 1'b0;
        if (tam == 2'd2) a[1:0] = 2'b00;
      end
      exp_er  = model_err(tam, a);
      exp_lat = model_lat(w, tam, a);
      exp_rd  = (exp_er || w) ? 32'h0 : model_load(tam, s, a);
      do_req(w, tam, s, a, d, lat, rd, er);
      n_vec++; if (rd !== exp_rd) begin n_err++; $display("FAIL rnd_data[%0d]: w=%b tam=%0d s=%b a=%h got %h want %h", n, w, tam, s, a, rd, exp_rd); end
      n_vec++; if (er !== exp_er) begin n_err++; $display("FAIL rnd_erro[%0d]: a=%h tam=%0d got %b want %b", n, a, tam, er, exp_er); end
      n_vec++; if (lat !== exp_lat) begin n_err++; $display("FAIL rnd_lat[%0d]: w=%b tam=%0d got %0d want %0d", n, w, tam, lat, exp_lat); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h0;
    test_reset();
    test_sw_lw();
    test_sb();
    test_sh();
    test_erro();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
